// File: rtl/clock_adjust_ctrl_if.sv
// Button inputs and digit-control outputs of the alarm-clock adjust front-end.
// slave = the controller side, master = whoever drives the buttons.
interface clock_adjust_ctrl_if;
  logic       btn_c;
  logic       btn_u;
  logic       btn_d;
  logic       btn_l;
  logic       btn_r;
  logic       tick;
  logic [3:0] en_clk;
  logic [3:0] en_alm;
  logic       dec;
  logic [1:0] mode;
  logic [1:0] sel;
  logic [3:0] blink;

  modport master (
    output btn_c, btn_u, btn_d, btn_l, btn_r,
    input  tick, en_clk, en_alm, dec, mode, sel, blink
  );

  modport slave (
    input  btn_c, btn_u, btn_d, btn_l, btn_r,
    output tick, en_clk, en_alm, dec, mode, sel, blink
  );
endinterface

// File: rtl/clock_adjust_ctrl.sv
// Alarm-clock control front-end: run tick prescaler, button debounce, mode FSM and digit adjust strobes.
// Define ADJ_BLINK_EN to build the 2 Hz blink mask for the selected digit; otherwise blink is tied low.
//
// state       | meaning
// ST_RUN      | clock running, tick active, u/d/l/r ignored
// ST_ADJ_CLK  | prescaler held, u/d strobe en_clk[sel], l/r move sel
// ST_ADJ_ALM  | prescaler held, u/d strobe en_alm[sel], l/r move sel
module clock_adjust_ctrl #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 1,
  parameter int DB_CYCLES = 500_000
) (
  input logic           clk,
  input logic           rst,
  clock_adjust_ctrl_if.slave bus
);

  localparam int PRE_TERM = CLK_HZ / TICK_HZ - 1;
  localparam int PW       = (PRE_TERM > 0) ? $clog2(PRE_TERM + 1) : 1;
  localparam int DW       = $clog2(DB_CYCLES + 1);
  localparam int NB       = 5;
  localparam int B_C      = 0;
  localparam int B_U      = 1;
  localparam int B_D      = 2;
  localparam int B_L      = 3;
  localparam int B_R      = 4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_ADJ_CLK = 2'd1,
    ST_ADJ_ALM = 2'd2
  } state_t;

  logic [NB-1:0] btn_raw;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] stable;
  logic [NB-1:0] stable_d;
  logic [NB-1:0] pulse;
  logic [DW-1:0] db_cnt [NB];

  logic [PW-1:0] pre_cnt;
  logic          tick_q;

  state_t        state_q;
  state_t        state_n;
  logic [1:0]    sel_q;
  logic [1:0]    sel_n;
  logic [3:0]    en_clk_q;
  logic [3:0]    en_clk_n;
  logic [3:0]    en_alm_q;
  logic [3:0]    en_alm_n;
  logic          dec_q;
  logic          dec_n;
  logic [3:0]    strobe;
  logic [3:0]    blink_q;

  assign btn_raw = {bus.btn_r, bus.btn_l, bus.btn_d, bus.btn_u, bus.btn_c};

  // The counter only runs while the synced level disagrees with the accepted one,
  // so any bounce back to the accepted level restarts the qualification window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < NB; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_d <= stable;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DB_CYCLES - 1)) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign pulse = stable & ~stable_d;

  // A c pulse leaving RUN also holds the prescaler so no tick escapes into adjust mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
      tick_q  <= 1'b0;
    end else if (state_q == ST_RUN && !pulse[B_C]) begin
      if (pre_cnt == PW'(PRE_TERM)) begin
        pre_cnt <= '0;
        tick_q  <= 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
        tick_q  <= 1'b0;
      end
    end else begin
      pre_cnt <= '0;
      tick_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      sel_q    <= 2'd0;
      en_clk_q <= 4'b0000;
      en_alm_q <= 4'b0000;
      dec_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      sel_q    <= sel_n;
      en_clk_q <= en_clk_n;
      en_alm_q <= en_alm_n;
      dec_q    <= dec_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    sel_n    = sel_q;
    en_clk_n = 4'b0000;
    en_alm_n = 4'b0000;
    dec_n    = 1'b0;
    strobe   = 4'b0000;
    if (pulse[B_C]) begin
      case (state_q)
        ST_RUN:     state_n = ST_ADJ_CLK;
        ST_ADJ_CLK: state_n = ST_ADJ_ALM;
        default:    state_n = ST_RUN;
      endcase
      sel_n = 2'd0;
    end else if (state_q != ST_RUN) begin
      if (pulse[B_L] && !pulse[B_R]) begin
        sel_n = sel_q + 2'd1;
      end else if (pulse[B_R] && !pulse[B_L]) begin
        sel_n = sel_q - 2'd1;
      end
      // Strobe targets the digit selected before any same-cycle l/r move.
      if (pulse[B_U] ^ pulse[B_D]) begin
        strobe = 4'b0001 << sel_q;
        dec_n  = pulse[B_D];
        if (state_q == ST_ADJ_CLK) begin
          en_clk_n = strobe;
        end else begin
          en_alm_n = strobe;
        end
      end
    end
  end

`ifdef ADJ_BLINK_EN
  localparam int BLK_HALF = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
  localparam int BW       = (BLK_HALF > 1) ? $clog2(BLK_HALF) : 1;

  logic [BW-1:0] blk_cnt;
  logic          blk_tog;

  // Toggle flips every quarter second, giving a 2 Hz square wave; user activity restarts it dark-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_cnt <= '0;
      blk_tog <= 1'b0;
      blink_q <= 4'b0000;
    end else begin
      if (pulse[B_C] | pulse[B_L] | pulse[B_R]) begin
        blk_cnt <= '0;
        blk_tog <= 1'b0;
      end else if (blk_cnt == BW'(BLK_HALF - 1)) begin
        blk_cnt <= '0;
        blk_tog <= ~blk_tog;
      end else begin
        blk_cnt <= blk_cnt + 1'b1;
      end
      blink_q <= (state_n != ST_RUN && blk_tog) ? (4'b0001 << sel_n) : 4'b0000;
    end
  end
`else
  assign blink_q = 4'b0000;
`endif

  assign bus.tick   = tick_q;
  assign bus.en_clk = en_clk_q;
  assign bus.en_alm = en_alm_q;
  assign bus.dec    = dec_q;
  assign bus.mode   = state_q;
  assign bus.sel    = sel_q;
  assign bus.blink  = blink_q;

endmodule

// File: tb/tb_clock_adjust_ctrl.sv
// Bench for clock_adjust_ctrl: table-driven button sequences, reset corner cases and random presses,
// all checked every cycle against an event-level model of mode, selection, strobes and tick.
module tb_clock_adjust_ctrl;
  localparam int CLK_HZ    = 10;
  localparam int TICK_HZ   = 1;
  localparam int DB_CYCLES = 4;
  localparam int PERIOD    = CLK_HZ / TICK_HZ;
  localparam int LAT       = DB_CYCLES + 2;
`ifdef ADJ_BLINK_EN
  localparam bit BLINK_BUILT = 1'b1;
`else
  localparam bit BLINK_BUILT = 1'b0;
`endif

  localparam logic [4:0] MC = 5'b00001;
  localparam logic [4:0] MU = 5'b00010;
  localparam logic [4:0] MD = 5'b00100;
  localparam logic [4:0] ML = 5'b01000;
  localparam logic [4:0] MR = 5'b10000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  clock_adjust_ctrl_if bus();

  clock_adjust_ctrl #(
    .CLK_HZ(CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         edge_no;
    logic [4:0] mask;
  } ev_t;
  ev_t evq[$];

  int         m_mode = 0;
  int         m_sel = 0;
  int         run_start = 0;
  bit         mon_en = 1'b0;
  int         tick_seen = 0;
  logic [3:0] seen_clk;
  logic [3:0] seen_alm;
  logic       seen_dec;
  int         seen_n;

  logic [4:0] mon_m;
  logic [3:0] mon_eclk;
  logic [3:0] mon_ealm;
  logic       mon_edec;
  logic       mon_etick;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: each debounced press takes effect LAT edges after the button is first
  // steadily high; effects are applied to an abstract mode/selection state.
  always @(negedge clk) begin
    if (rst && mon_en) begin
      mon_m = 5'b00000;
      for (int i = evq.size() - 1; i >= 0; i--) begin
        if (evq[i].edge_no == cyc) begin
          mon_m = mon_m | evq[i].mask;
          evq.delete(i);
        end
      end
      mon_eclk = 4'b0000;
      mon_ealm = 4'b0000;
      mon_edec = 1'b0;
      if (mon_m[0]) begin
        m_mode = (m_mode + 1) % 3;
        m_sel  = 0;
        if (m_mode == 0) run_start = cyc;
      end else if (m_mode != 0) begin
        if (mon_m[1] ^ mon_m[2]) begin
          if (m_mode == 1) mon_eclk = 4'(1 << m_sel);
          else             mon_ealm = 4'(1 << m_sel);
          mon_edec = mon_m[2];
        end
        if (mon_m[3] && !mon_m[4])      m_sel = (m_sel + 1) % 4;
        else if (mon_m[4] && !mon_m[3]) m_sel = (m_sel + 3) % 4;
      end
      mon_etick = (m_mode == 0) && (cyc > run_start) && ((cyc - run_start) % PERIOD == 0);
      check("tick", int'(bus.tick), int'(mon_etick));
      check("mode", int'(bus.mode), m_mode);
      check("sel", int'(bus.sel), m_sel);
      check("en_clk", int'(bus.en_clk), int'(mon_eclk));
      check("en_alm", int'(bus.en_alm), int'(mon_ealm));
      check("dec", int'(bus.dec), int'(mon_edec));
      if (m_mode == 0 || !BLINK_BUILT) check("blink", int'(bus.blink), 0);
      if (bus.tick) tick_seen++;
      seen_clk = seen_clk | bus.en_clk;
      seen_alm = seen_alm | bus.en_alm;
      if (bus.en_clk != 0 || bus.en_alm != 0) begin
        seen_n++;
        seen_dec = seen_dec | bus.dec;
      end
    end
  end

  task automatic drive(input logic [4:0] mask);
    bus.btn_c = mask[0];
    bus.btn_u = mask[1];
    bus.btn_d = mask[2];
    bus.btn_l = mask[3];
    bus.btn_r = mask[4];
  endtask

  task automatic press(input logic [4:0] mask, input int hold, input bit bounce, output int eff);
    seen_clk = 4'b0000;
    seen_alm = 4'b0000;
    seen_dec = 1'b0;
    seen_n   = 0;
    @(negedge clk); #1;
    if (bounce) begin
      drive(mask);
      @(negedge clk); #1;
      drive(5'b00000);
      @(negedge clk); #1;
    end
    drive(mask);
    eff = cyc + 1 + LAT;
    evq.push_back('{eff, mask});
    repeat (hold) @(negedge clk);
    #1;
    drive(5'b00000);
    repeat (DB_CYCLES + 6) @(negedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tick"}, int'(bus.tick), 0);
    check({tag, "_en_clk"}, int'(bus.en_clk), 0);
    check({tag, "_en_alm"}, int'(bus.en_alm), 0);
    check({tag, "_dec"}, int'(bus.dec), 0);
    check({tag, "_mode"}, int'(bus.mode), 0);
    check({tag, "_sel"}, int'(bus.sel), 0);
    check({tag, "_blink"}, int'(bus.blink), 0);
  endtask

  typedef struct {
    logic [4:0] mask;
    bit         bounce;
    int         mode;
    int         sel;
    logic [3:0] eclk;
    logic [3:0] ealm;
    logic       edec;
  } vec_t;
  vec_t tbl[15];

  initial begin
    int eff;
    logic [4:0] rmask;

    tbl[0]  = '{MC,      1'b1, 1, 0, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{ML,      1'b0, 1, 1, 4'b0000, 4'b0000, 1'b0};
    tbl[2]  = '{ML,      1'b0, 1, 2, 4'b0000, 4'b0000, 1'b0};
    tbl[3]  = '{MU,      1'b0, 1, 2, 4'b0100, 4'b0000, 1'b0};
    tbl[4]  = '{ML,      1'b0, 1, 3, 4'b0000, 4'b0000, 1'b0};
    tbl[5]  = '{ML,      1'b0, 1, 0, 4'b0000, 4'b0000, 1'b0};
    tbl[6]  = '{MR,      1'b0, 1, 3, 4'b0000, 4'b0000, 1'b0};
    tbl[7]  = '{MD,      1'b0, 1, 3, 4'b1000, 4'b0000, 1'b1};
    tbl[8]  = '{MC,      1'b0, 2, 0, 4'b0000, 4'b0000, 1'b0};
    tbl[9]  = '{MU | MD, 1'b0, 2, 0, 4'b0000, 4'b0000, 1'b0};
    tbl[10] = '{ML | MR, 1'b0, 2, 0, 4'b0000, 4'b0000, 1'b0};
    tbl[11] = '{MU,      1'b0, 2, 0, 4'b0000, 4'b0001, 1'b0};
    tbl[12] = '{MC | MU, 1'b0, 0, 0, 4'b0000, 4'b0000, 1'b0};
    tbl[13] = '{MU,      1'b0, 0, 0, 4'b0000, 4'b0000, 1'b0};
    tbl[14] = '{ML,      1'b1, 0, 0, 4'b0000, 4'b0000, 1'b0};

    drive(5'b00000);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    m_mode = 0;
    m_sel = 0;
    run_start = cyc;
    mon_en = 1'b1;

    tick_seen = 0;
    repeat (35) @(negedge clk);
    #1;
    check("idle_tick_count", tick_seen, 3);

    for (int i = 0; i < 15; i++) begin
      press(tbl[i].mask, 8, tbl[i].bounce, eff);
      check($sformatf("vec%0d_mode", i), int'(bus.mode), tbl[i].mode);
      check($sformatf("vec%0d_sel", i), int'(bus.sel), tbl[i].sel);
      check($sformatf("vec%0d_en_clk", i), int'(seen_clk), int'(tbl[i].eclk));
      check($sformatf("vec%0d_en_alm", i), int'(seen_alm), int'(tbl[i].ealm));
      check($sformatf("vec%0d_dec", i), int'(seen_dec), int'(tbl[i].edec));
      check($sformatf("vec%0d_strobes", i), seen_n, (tbl[i].eclk != 0 || tbl[i].ealm != 0) ? 1 : 0);
    end

    // Back in RUN: count ticks over a fixed window to confirm the full-period restart.
    tick_seen = 0;
    repeat (25) @(negedge clk);
    #1;
    check("run_tick_count", tick_seen, 2);

    // Reset asserted in the middle of an alarm-bank strobe.
    press(MC, 8, 1'b0, eff);
    press(MC, 8, 1'b0, eff);
    @(negedge clk); #1;
    drive(MU);
    eff = cyc + 1 + LAT;
    evq.push_back('{eff, MU});
    do @(negedge clk); while (cyc < eff);
    #1;
    check("pre_rst_en_alm", int'(bus.en_alm), 1);
    rst = 1'b0;
    #1;
    check_all_zero("mid_strobe_rst");
    mon_en = 1'b0;
    drive(5'b00000);
    evq.delete();
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    m_mode = 0;
    m_sel = 0;
    run_start = cyc;
    mon_en = 1'b1;

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:       rmask = MC;
        1, 2:    rmask = MU;
        3, 4:    rmask = MD;
        5, 6:    rmask = ML;
        7, 8:    rmask = MR;
        default: rmask = 5'(1 << $urandom_range(0, 4)) | 5'(1 << $urandom_range(0, 4));
      endcase
      press(rmask, $urandom_range(6, 10), ($urandom_range(0, 3) == 0), eff);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
